// File: rtl/sram_phase_scheduler.sv
// Top-level decode sequencer: UART load -> M2 (IDCT) -> M1 (CSC) -> VGA display,
// with one-cycle turnaround gaps and a single shared SRAM port muxed to the owner.
module sram_phase_scheduler #(
  parameter logic [23:0] TIMEOUT = 24'd16_000_000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  output logic        UART_Enable,
  output logic        M2_Enable,
  output logic        M1_Enable,
  output logic        VGA_Enable,
  input  logic        UART_Stop,
  input  logic        M2_Stop,
  input  logic        M1_Stop,
  input  logic [17:0] UART_SRAM_address,
  input  logic [17:0] M2_SRAM_address,
  input  logic [17:0] M1_SRAM_address,
  input  logic [17:0] VGA_SRAM_address,
  input  logic [15:0] UART_SRAM_write_data,
  input  logic [15:0] M2_SRAM_write_data,
  input  logic [15:0] M1_SRAM_write_data,
  input  logic        UART_SRAM_we_n,
  input  logic        M2_SRAM_we_n,
  input  logic        M1_SRAM_we_n,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic [2:0]  Phase,
  output logic        Busy,
  output logic        Error,
  output logic [23:0] Last_cycles
);

  // state     | meaning
  // S_IDLE    | waiting for Start, SRAM idle
  // S_UART    | image load owns SRAM
  // S_GAP1    | turnaround UART -> M2
  // S_M2      | IDCT owns SRAM
  // S_GAP2    | turnaround M2 -> M1
  // S_M1      | colourspace conversion owns SRAM
  // S_GAP3    | turnaround M1 -> display
  // S_DISPLAY | VGA reads SRAM, Start restarts
  // S_ERROR   | a stage exceeded TIMEOUT, Start restarts
  typedef enum logic [3:0] {
    S_IDLE, S_UART, S_GAP1, S_M2, S_GAP2, S_M1, S_GAP3, S_DISPLAY, S_ERROR
  } state_t;

  localparam logic [23:0] TERM_CNT = TIMEOUT - 24'd1;

  state_t      state_q, state_d;
  state_t      stop_next;
  logic [23:0] phase_cnt_q, phase_cnt_d;
  logic [23:0] last_cycles_q, last_cycles_d;
  logic        active, stop, entering_active;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q       <= S_IDLE;
      phase_cnt_q   <= '0;
      last_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      phase_cnt_q   <= phase_cnt_d;
      last_cycles_q <= last_cycles_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    phase_cnt_d   = phase_cnt_q;
    last_cycles_d = last_cycles_q;
    active        = 1'b0;
    stop          = 1'b0;
    stop_next     = S_IDLE;

    unique case (state_q)
      S_IDLE, S_DISPLAY, S_ERROR: if (Start) state_d = S_UART;
      S_UART: begin active = 1'b1; stop = UART_Stop; stop_next = S_GAP1; end
      S_M2:   begin active = 1'b1; stop = M2_Stop;   stop_next = S_GAP2; end
      S_M1:   begin active = 1'b1; stop = M1_Stop;   stop_next = S_GAP3; end
      S_GAP1: state_d = S_M2;
      S_GAP2: state_d = S_M1;
      S_GAP3: state_d = S_DISPLAY;
      default: state_d = S_IDLE;
    endcase

    // A Stop seen on the first cycle of a stage is a leftover and is ignored;
    // an honoured Stop takes priority over the timeout.
    if (active) begin
      if (stop && (phase_cnt_q != 24'd0)) begin
        state_d       = stop_next;
        last_cycles_d = phase_cnt_q + 24'd1;
      end else if (phase_cnt_q == TERM_CNT) begin
        state_d = S_ERROR;
      end
    end

    entering_active = (state_d != state_q) &&
                      ((state_d == S_UART) || (state_d == S_M2) || (state_d == S_M1));
    if (entering_active)
      phase_cnt_d = '0;
    else if (active && !(&phase_cnt_q))
      phase_cnt_d = phase_cnt_q + 24'd1;
  end

  always_comb begin
    UART_Enable     = (state_q == S_UART);
    M2_Enable       = (state_q == S_M2);
    M1_Enable       = (state_q == S_M1);
    VGA_Enable      = (state_q == S_DISPLAY);
    Error           = (state_q == S_ERROR);
    Busy            = 1'b0;
    Phase           = 3'd0;
    SRAM_address    = '0;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;

    unique case (state_q)
      S_UART: begin
        Phase = 3'd1; Busy = 1'b1;
        SRAM_address    = UART_SRAM_address;
        SRAM_write_data = UART_SRAM_write_data;
        SRAM_we_n       = UART_SRAM_we_n;
      end
      S_M2: begin
        Phase = 3'd2; Busy = 1'b1;
        SRAM_address    = M2_SRAM_address;
        SRAM_write_data = M2_SRAM_write_data;
        SRAM_we_n       = M2_SRAM_we_n;
      end
      S_M1: begin
        Phase = 3'd3; Busy = 1'b1;
        SRAM_address    = M1_SRAM_address;
        SRAM_write_data = M1_SRAM_write_data;
        SRAM_we_n       = M1_SRAM_we_n;
      end
      S_GAP1, S_GAP2, S_GAP3: begin
        Phase = 3'd5; Busy = 1'b1;
      end
      S_DISPLAY: begin
        Phase        = 3'd4;
        SRAM_address = VGA_SRAM_address;
      end
      S_ERROR: Phase = 3'd7;
      default: Phase = 3'd0;
    endcase
  end

  assign Last_cycles = last_cycles_q;

endmodule

// File: tb/tb_sram_phase_scheduler.sv
// Directed bench: expected output vectors are queued when inputs are driven
// and popped for comparison one cycle later when the DUT has responded.
module tb_sram_phase_scheduler;

  logic        clk = 1'b0;
  logic        Resetn, Start;
  logic        UART_Enable, M2_Enable, M1_Enable, VGA_Enable;
  logic        UART_Stop, M2_Stop, M1_Stop;
  logic [17:0] UART_SRAM_address, M2_SRAM_address, M1_SRAM_address, VGA_SRAM_address;
  logic [15:0] UART_SRAM_write_data, M2_SRAM_write_data, M1_SRAM_write_data;
  logic        UART_SRAM_we_n, M2_SRAM_we_n, M1_SRAM_we_n;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [2:0]  Phase;
  logic        Busy, Error;
  logic [23:0] Last_cycles;

  sram_phase_scheduler #(.TIMEOUT(24'd20)) dut (
    .Clock(clk), .Resetn(Resetn), .Start(Start),
    .UART_Enable(UART_Enable), .M2_Enable(M2_Enable), .M1_Enable(M1_Enable),
    .VGA_Enable(VGA_Enable),
    .UART_Stop(UART_Stop), .M2_Stop(M2_Stop), .M1_Stop(M1_Stop),
    .UART_SRAM_address(UART_SRAM_address), .M2_SRAM_address(M2_SRAM_address),
    .M1_SRAM_address(M1_SRAM_address), .VGA_SRAM_address(VGA_SRAM_address),
    .UART_SRAM_write_data(UART_SRAM_write_data), .M2_SRAM_write_data(M2_SRAM_write_data),
    .M1_SRAM_write_data(M1_SRAM_write_data),
    .UART_SRAM_we_n(UART_SRAM_we_n), .M2_SRAM_we_n(M2_SRAM_we_n), .M1_SRAM_we_n(M1_SRAM_we_n),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
    .Phase(Phase), .Busy(Busy), .Error(Error), .Last_cycles(Last_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [67:0] v;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [23:0] exp_last = 24'd0;

  // Expected {Phase,Busy,Error,enables,we_n,addr,data,Last_cycles} for a phase code,
  // using the stage inputs currently being driven.
  function automatic logic [67:0] exp_vec(input logic [2:0] ph);
    logic        busy, err, ue, m2e, m1e, ve, we;
    logic [17:0] a;
    logic [15:0] d;
    busy = (ph == 3'd1) || (ph == 3'd2) || (ph == 3'd3) || (ph == 3'd5);
    err  = (ph == 3'd7);
    ue   = (ph == 3'd1);
    m2e  = (ph == 3'd2);
    m1e  = (ph == 3'd3);
    ve   = (ph == 3'd4);
    a = 18'd0; d = 16'd0; we = 1'b1;
    if (ph == 3'd1) begin a = UART_SRAM_address; d = UART_SRAM_write_data; we = UART_SRAM_we_n; end
    if (ph == 3'd2) begin a = M2_SRAM_address;   d = M2_SRAM_write_data;   we = M2_SRAM_we_n;   end
    if (ph == 3'd3) begin a = M1_SRAM_address;   d = M1_SRAM_write_data;   we = M1_SRAM_we_n;   end
    if (ph == 3'd4) a = VGA_SRAM_address;
    return {ph, busy, err, ue, m2e, m1e, ve, we, a, d, exp_last};
  endfunction

  task automatic step(input string tag, input logic [2:0] ph);
    exp_t        e;
    logic [67:0] obs;
    exp_q.push_back('{tag, exp_vec(ph)});
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    obs = {Phase, Busy, Error, UART_Enable, M2_Enable, M1_Enable, VGA_Enable,
           SRAM_we_n, SRAM_address, SRAM_write_data, Last_cycles};
    checks++;
    assert (obs === e.v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
    end
  endtask

  task automatic scramble();
    UART_SRAM_address    = 18'($urandom); UART_SRAM_write_data = 16'($urandom);
    M2_SRAM_address      = 18'($urandom); M2_SRAM_write_data   = 16'($urandom);
    M1_SRAM_address      = 18'($urandom); M1_SRAM_write_data   = 16'($urandom);
    VGA_SRAM_address     = 18'($urandom);
    UART_SRAM_we_n = 1'b0; M2_SRAM_we_n = 1'($urandom); M1_SRAM_we_n = 1'b0;
  endtask

  // Stop held low for 10 owner cycles then high for one -> 11 enable cycles.
  task automatic run_stage(input string tag, input logic [2:0] ph, input int which);
    for (int i = 0; i < 10; i++) step({tag, "_run"}, ph);
    if (which == 1) UART_Stop = 1'b1;
    if (which == 2) M2_Stop = 1'b1;
    if (which == 3) M1_Stop = 1'b1;
    exp_last = 24'd11;
    step({tag, "_gap"}, 3'd5);
    UART_Stop = 1'b0; M2_Stop = 1'b0; M1_Stop = 1'b0;
  endtask

  initial begin
    Resetn = 1'b0; Start = 1'b0;
    UART_Stop = 1'b0; M2_Stop = 1'b0; M1_Stop = 1'b0;
    UART_SRAM_address = 18'h00123; UART_SRAM_write_data = 16'hBEEF; UART_SRAM_we_n = 1'b0;
    M2_SRAM_address   = 18'h3FFFF; M2_SRAM_write_data   = 16'h1234; M2_SRAM_we_n   = 1'b0;
    M1_SRAM_address   = 18'h0ABCD; M1_SRAM_write_data   = 16'h5A5A; M1_SRAM_we_n   = 1'b0;
    VGA_SRAM_address  = 18'h2AAAA;

    step("reset0", 3'd0);
    step("reset1", 3'd0);
    Resetn = 1'b1;
    step("idle", 3'd0);

    // Full nominal run
    Start = 1'b1;
    step("start_uart", 3'd1);
    Start = 1'b0;
    run_stage("uart", 3'd1, 1);
    step("m2_entry", 3'd2);
    run_stage("m2", 3'd2, 2);
    step("m1_entry", 3'd3);
    run_stage("m1", 3'd3, 3);
    step("display", 3'd4);
    step("display_hold", 3'd4);

    // Stale Stop on first M2 cycle
    Start = 1'b1;
    step("restart_uart", 3'd1);
    Start = 1'b0;
    step("uart_c2", 3'd1);
    UART_Stop = 1'b1;
    exp_last = 24'd2;
    step("uart_stop2", 3'd5);
    UART_Stop = 1'b0;
    M2_Stop = 1'b1;
    step("m2_stale_entry", 3'd2);
    step("m2_stale_ignored", 3'd2);
    step("m2_stop_c2", 3'd5);
    M2_Stop = 1'b0;

    // M1 timeout: 20 enable cycles then error
    scramble();
    step("m1_to_entry", 3'd3);
    for (int i = 0; i < 19; i++) begin
      scramble();
      step("m1_to_run", 3'd3);
    end
    step("m1_timeout", 3'd7);
    M1_Stop = 1'b1; UART_Stop = 1'b1;
    step("error_hold", 3'd7);
    M1_Stop = 1'b0; UART_Stop = 1'b1;
    Start = 1'b1;
    step("error_restart", 3'd1);
    Start = 1'b0;

    // Stop coincident with timeout wins; UART_Stop still high is stale here
    step("uart_stale", 3'd1);
    exp_last = 24'd2;
    step("uart_stop", 3'd5);
    UART_Stop = 1'b0;
    step("m2_entry2", 3'd2);
    for (int i = 0; i < 18; i++) begin
      scramble();
      step("m2_to_run", 3'd2);
    end
    step("m2_c20", 3'd2);
    M2_Stop = 1'b1;
    exp_last = 24'd20;
    step("m2_stop_at_timeout", 3'd5);
    M2_Stop = 1'b0;
    step("m1_entry2", 3'd3);

    // Start ignored mid-run
    Start = 1'b1;
    step("m1_start_ign1", 3'd3);
    step("m1_start_ign2", 3'd3);
    Start = 1'b0;
    M1_Stop = 1'b1;
    exp_last = 24'd3;
    step("m1_stop3", 3'd5);
    M1_Stop = 1'b0;
    step("display2", 3'd4);

    // Reset during M2 overrides Start and Stop
    Start = 1'b1;
    step("uart3", 3'd1);
    Start = 1'b0; UART_Stop = 1'b1;
    step("uart3_stale", 3'd1);
    exp_last = 24'd2;
    step("uart3_stop", 3'd5);
    UART_Stop = 1'b0;
    step("m2_pre_reset", 3'd2);
    step("m2_pre_reset2", 3'd2);
    Resetn = 1'b0; Start = 1'b1; M2_Stop = 1'b1;
    exp_last = 24'd0;
    step("mid_reset", 3'd0);
    Resetn = 1'b1; Start = 1'b0; M2_Stop = 1'b0;
    step("post_reset_idle", 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_phase_scheduler.md
# sram_phase_scheduler

Top-level sequencer and SRAM port arbiter for the decompressor. It runs the four stages in order: UART image load, milestone 2 (IDCT), milestone 1 (colourspace conversion), then VGA display. It drives each stage's Enable and watches its Stop, and it multiplexes the single external SRAM port to whichever stage currently owns it. SRAM_read_data fans out to all stages directly and does not pass through this block.

## Interface
Parameters:
- TIMEOUT, 24'd16_000_000: maximum cycles allowed per active stage before the block declares an error.

Ports:
- Clock  in  1  system clock; the only clock.
- Resetn  in  1  reset, synchronous and active-low.
- Start  in  1  begins a new decode run; sampled only in S_IDLE, S_DISPLAY and S_ERROR.
- UART_Enable / M2_Enable / M1_Enable  out  1 each  level enables, high throughout the owner's phase.
- UART_Stop / M2_Stop / M1_Stop  in  1 each  stage-finished indicators.
- VGA_Enable  out  1  high in S_DISPLAY.
- UART_SRAM_address / M2_SRAM_address / M1_SRAM_address / VGA_SRAM_address  in  18 each.
- UART_SRAM_write_data / M2_SRAM_write_data / M1_SRAM_write_data  in  16 each.
- UART_SRAM_we_n / M2_SRAM_we_n / M1_SRAM_we_n  in  1 each.
- SRAM_address  out  18  muxed address.
- SRAM_write_data  out  16  muxed write data.
- SRAM_we_n  out  1  muxed write enable, active-low.
- Phase  out  3  status code: 0 idle, 1 UART, 2 M2, 3 M1, 4 display, 5 gap, 7 error.
- Busy  out  1  high in S_UART, S_M2, S_M1 and the gap states.
- Error  out  1  high in S_ERROR.
- Last_cycles  out  24  cycle count of the most recently completed stage.

## Operation
- States: S_IDLE, S_UART, S_GAP1, S_M2, S_GAP2, S_M1, S_GAP3, S_DISPLAY, S_ERROR.
- Transitions out of idle/display/error:
  - S_IDLE, S_DISPLAY or S_ERROR with Start=1 -> S_UART.
  - Start is ignored in every other state.
- Transitions out of active stages:
  - S_UART -> S_GAP1 on UART_Stop.
  - S_M2 -> S_GAP2 on M2_Stop.
  - S_M1 -> S_GAP3 on M1_Stop.
  - Stop is honoured only when phase_cnt >= 1, so a stale Stop in the first phase cycle is ignored.
- Gap transitions (each gap lasts exactly 1 cycle): S_GAP1 -> S_M2, S_GAP2 -> S_M1, S_GAP3 -> S_DISPLAY.
- Timeout: in any active stage, phase_cnt == TIMEOUT-1 with no Stop -> S_ERROR.
  - If Stop and timeout occur in the same cycle, Stop wins.
- Enables are a decode of the registered state, so they are glitch-free and have no extra latency:
  - X_Enable = (state == S_X).
  - VGA_Enable = (state == S_DISPLAY).
- SRAM mux (combinational on the registered state):
  - S_UART, S_M2, S_M1: that stage's address, data and we_n.
  - S_DISPLAY: VGA_SRAM_address, write_data 0, we_n 1.
  - All other states: address 0, data 0, we_n 1. No write can ever occur outside an active stage.
- phase_cnt (24 bit):
  - Clears to 0 on entry to any active stage.
  - Increments every cycle while in an active stage and saturates at all-ones.
  - On an honoured Stop, Last_cycles <= phase_cnt + 1, i.e. the number of cycles Enable was high.
- S_ERROR: all enables low, SRAM idle, Error=1. Leaves only on Start or reset.

## Timing
- Reset values (the cycle after a clock edge with Resetn=0):
  - State S_IDLE, so every Enable = 0, SRAM_address = 0, SRAM_write_data = 0, SRAM_we_n = 1.
  - Phase = 0, Busy = 0, Error = 0, Last_cycles = 0, phase_cnt = 0.
- Reset asserted mid-run aborts at the next edge. It overrides Start, Stop and timeout.
- Start at edge N -> UART_Enable = 1 and the SRAM owned by UART from cycle N+1.
- Stop for X sampled at edge N -> X_Enable = 0 and the SRAM idle (we_n = 1) in cycle N+1 (gap) -> next Enable = 1 in cycle N+2.
- The turnaround gap of exactly 1 cycle guarantees that two stages never drive the SRAM in the same or adjacent cycles.
- Stage outputs switch in the same cycle as the state; this block adds no pipeline delay on address, data or we_n.

## Test plan
- Reset then Start pulse; hold each Stop low for 10 cycles, then raise it for 1 cycle -> Phase steps 1,5,2,5,3,5,4; each Enable is high exactly 11 cycles; Last_cycles = 11 after each stage; VGA_Enable = 1 at the end.
- Mux check: UART drives addr 18'h00123, data 16'hBEEF, we_n 0, and M2 drives 18'h3FFFF -> SRAM shows only the owner's values; we_n = 1 in every gap cycle and in S_IDLE.
- Stale Stop: M2_Stop held high on the first cycle of S_M2 -> ignored; transition occurs on the second cycle, with Last_cycles = 2.
- Timeout with TIMEOUT = 24'd20 and M1_Stop never asserted -> S_ERROR after 20 cycles of M1_Enable; Error = 1, Phase = 7, SRAM we_n = 1; a later Start restarts at S_UART with Error = 0.
- Stop and timeout together: M2_Stop on cycle 20 with TIMEOUT = 20 -> goes to S_GAP2, not S_ERROR.
- Resetn low during S_M2, and Start pulsed during S_M1 -> reset returns all outputs to reset values at the next edge; the mid-run Start has no effect.
